// File: rtl/fetch_queue_if.sv
// Bundle of the fetch_queue handshake signals: redirect input, instruction memory port, decode port.
// master is the fetch_queue side, slave is the environment (execute, memory, decode).
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_bundle;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;
  logic [CNT_W-1:0]  fill_level;

  modport master (
    input  redirect_valid, redirect_pc, mem_rdata, out_ready,
    output mem_req, mem_addr, out_valid, out_bundle, out_pc, fill_level
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_rdata, out_ready,
    input  mem_req, mem_addr, out_valid, out_bundle, out_pc, fill_level
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: sequential fetch into a small {bundle, pc} FIFO,
// credit-based request issue, and flush-and-restart on redirect.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_bundle [DEPTH];
  logic [ADDR_W-1:0] r_pc     [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic              w_req;
  logic              w_valid;
  logic [CNT_W:0]    w_credit;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.out_ready;
  assign w_push  = r_inflight && !bus.redirect_valid;

  // Occupancy after this cycle's pop, with the in-flight response already reserved.
  assign w_credit = {1'b0, r_count} - (CNT_W+1)'(w_pop) + (CNT_W+1)'(r_inflight);
  assign w_req    = rst_n && !bus.redirect_valid && (w_credit < (CNT_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= '0;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_inflight    <= w_req;
      r_inflight_pc <= r_fetch_pc;
      if (bus.redirect_valid) begin
        r_fetch_pc <= bus.redirect_pc;
        r_rd_ptr   <= r_wr_ptr;
        r_count    <= '0;
      end else begin
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + ADDR_W'(2);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Storage needs no reset: the head is masked by out_valid until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bundle[r_wr_ptr] <= bus.mem_rdata;
      r_pc[r_wr_ptr]     <= r_inflight_pc;
    end
  end

  assign bus.mem_req    = w_req;
  assign bus.mem_addr   = r_fetch_pc;
  assign bus.out_valid  = w_valid;
  assign bus.out_bundle = w_valid ? r_bundle[r_rd_ptr] : '0;
  assign bus.out_pc     = w_valid ? r_pc[r_rd_ptr] : '0;
  assign bus.fill_level = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model returns {pc,pc} per word, a scoreboard
// queue of expected PCs is checked by a monitor on every decode handshake.
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFail;
  int   reqCnt;
  logic [ADDR_W-1:0] expQ[$];
  logic [ADDR_W-1:0] sbPc;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] bundleOf(input logic [ADDR_W-1:0] pc);
    return {20'd0, pc, 20'd0, pc};
  endfunction

  // Fixed one-cycle-latency instruction memory
  always @(posedge clk) begin
    if (bus.mem_req) begin
      bus.mem_rdata <= bundleOf(bus.mem_addr);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [ADDR_W-1:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.out_ready      = rdy;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every accepted bundle must be the next expected PC
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL sb_unexpected: got pc 0x%0h, expected no delivery at t=%0t", bus.out_pc, $time);
      end else begin
        sbPc = expQ.pop_front();
        checkOutput("sb_pc", 64'(bus.out_pc), 64'(sbPc));
        checkOutput("sb_bundle", bus.out_bundle, bundleOf(sbPc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nFail   = 0;
    reqCnt  = 0;
    rst_n   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;

    #12;
    checkOutput("rst_mem_req",    64'(bus.mem_req),    64'd0);
    checkOutput("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
    checkOutput("rst_out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("rst_fill_level", 64'(bus.fill_level), 64'd0);
    checkOutput("rst_out_bundle", bus.out_bundle,      64'd0);
    checkOutput("rst_out_pc",     64'(bus.out_pc),     64'd0);

    // Streaming from reset release, PCs 0..14 accepted on cycles 2..9
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("c0_mem_req",   64'(bus.mem_req),   64'd1);
    checkOutput("c0_mem_addr",  64'(bus.mem_addr),  64'd0);
    checkOutput("c0_out_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < 8; k++) expQ.push_back(ADDR_W'(2 * k));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("c1_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("c1_mem_addr",  64'(bus.mem_addr),  64'd2);
    for (int c = 2; c < 10; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("stream_valid", 64'(bus.out_valid), 64'd1);
    end

    // Stall until full, then asynchronous reset while full
    for (int c = 10; c < 16; c++) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("full_fill_level", 64'(bus.fill_level), 64'd4);
    checkOutput("full_mem_req",    64'(bus.mem_req),    64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("async_fill_level", 64'(bus.fill_level), 64'd0);
    checkOutput("async_out_pc",     64'(bus.out_pc),     64'd0);
    checkOutput("async_out_bundle", bus.out_bundle,      64'd0);
    checkOutput("async_mem_addr",   64'(bus.mem_addr),   64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Backpressure from reset: exactly four requests, PCs 0,2,4,6
    for (int c = 0; c < 10; c++) begin
      if (c > 0) applyStimulus(1'b0, '0, 1'b0);
      if (bus.mem_req) begin
        checkOutput("bp_req_addr", 64'(bus.mem_addr), 64'(2 * reqCnt));
        reqCnt++;
      end
    end
    checkOutput("bp_req_count",  64'(reqCnt),         64'd4);
    checkOutput("bp_fill_level", 64'(bus.fill_level), 64'd4);
    checkOutput("bp_mem_req",    64'(bus.mem_req),    64'd0);

    for (int k = 0; k < 8; k++) expQ.push_back(ADDR_W'(2 * k));
    for (int c = 10; c < 18; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("bp_release_valid", 64'(bus.out_valid), 64'd1);
    end

    // Redirect with 3 entries held and one request in flight
    applyStimulus(1'b1, 12'h100, 1'b0);
    checkOutput("rd_n_fill_level", 64'(bus.fill_level), 64'd3);
    checkOutput("rd_n_mem_req",    64'(bus.mem_req),    64'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rd_n1_fill_level", 64'(bus.fill_level), 64'd0);
    checkOutput("rd_n1_out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("rd_n1_mem_req",    64'(bus.mem_req),    64'd1);
    checkOutput("rd_n1_mem_addr",   64'(bus.mem_addr),   64'h100);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rd_n2_out_valid", 64'(bus.out_valid), 64'd0);
    expQ.push_back(12'h100);
    expQ.push_back(12'h102);
    expQ.push_back(12'h104);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rd_n3_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("rd_n3_out_pc",    64'(bus.out_pc),    64'h100);
    applyStimulus(1'b0, '0, 1'b1);

    // Redirect coinciding with a pop, restarting near the top of the address space
    applyStimulus(1'b1, 12'hFFC, 1'b1);
    checkOutput("rdpop_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("rdpop_out_pc",    64'(bus.out_pc),    64'h104);
    checkOutput("rdpop_mem_req",   64'(bus.mem_req),   64'd0);
    expQ.push_back(12'hFFC);
    expQ.push_back(12'hFFE);
    expQ.push_back(12'h000);
    expQ.push_back(12'h002);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("wrap_m1_out_valid",  64'(bus.out_valid),  64'd0);
    checkOutput("wrap_m1_mem_addr",   64'(bus.mem_addr),   64'hFFC);
    checkOutput("wrap_m1_fill_level", 64'(bus.fill_level), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("wrap_m2_out_valid", 64'(bus.out_valid), 64'd0);
    for (int c = 3; c < 7; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("wrap_valid", 64'(bus.out_valid), 64'd1);
    end

    // Head must hold steady under backpressure
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("hold_pc_a", 64'(bus.out_pc), 64'h004);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("hold_pc_b",     64'(bus.out_pc),     64'h004);
    checkOutput("hold_bundle_b", bus.out_bundle,      bundleOf(12'h004));
    checkOutput("sb_drained",    64'(expQ.size()),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
